midi_uart_rx: RTL

- Serial receiver for the MIDI IN line: 31250 baud, 8N1, LSB first.
- Consumes the single-cycle oversample strobe produced by the clock-divider stage (divide-by-N, configured for 16x baud). Emits one byte per received frame to the downstream MIDI message parser.
- All state advances only on strobe cycles. Output pulses are one clk wide.

---
 rtl/midi_uart_rx_if.sv | 13 +
 rtl/midi_uart_rx.sv | 92 +++++++++
 2 files changed

// File: rtl/midi_uart_rx_if.sv
// midi_uart_rx_if: line/strobe inputs and byte outputs of the MIDI receiver
// master: drives tick and rx, observes data/valid/frame_err/busy
// slave:  the receiver side
interface midi_uart_rx_if;
  logic       tick;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  modport master(output tick, rx, input data, valid, frame_err, busy);
  modport slave(input tick, rx, output data, valid, frame_err, busy);
endinterface

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 LSB-first MIDI serial receiver driven by an oversample strobe
// clk/rst: system clock, synchronous active-high reset
// bus.tick/bus.rx in; bus.data (held byte), bus.valid, bus.frame_err (1-clk pulses), bus.busy out
module midi_uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input logic          clk,
  input logic          rst,
  midi_uart_rx_if.slave bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitn_q, bitn_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic [1:0]    sync_q, sync_d;
  logic          rx_s;
  assign rx_s = sync_q[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      sync_q  <= sync_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    sync_d  = {sync_q[0], bus.rx};
    if (bus.tick) begin
      case (state_q)
        IDLE: if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
        // a line that rises again before the start-bit centre is a glitch
        START: if (rx_s) state_d = IDLE;
        else if (cnt_q == CNT_MID) begin
          state_d = DATA;
          cnt_d   = '0;
          bitn_d  = '0;
        end else cnt_d = cnt_q + CW'(1);
        DATA: if (cnt_q == CNT_MAX) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = '0;
          bitn_d  = bitn_q + 3'd1;
          state_d = bitn_q == 3'd7 ? STOP : DATA;
        end else cnt_d = cnt_q + CW'(1);
        // leaving at the stop-bit centre lets a back-to-back start edge be caught
        STOP: if (cnt_q == CNT_MAX) begin
          state_d = rx_s ? IDLE : BREAK;
          data_d  = rx_s ? shift_q : data_q;
          valid_d = rx_s;
          ferr_d  = !rx_s;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
        // wait for the line to rise so a held-low line is not read as 0x00 frames
        BREAK: if (rx_s) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = state_q != IDLE;
endmodule
